mag_comparator_seq: RTL and testbench

MAG_COMPARATOR_SEQ -- requirements
Module: mag_comparator_seq

---
 rtl/mag_comparator_seq.sv | 120 ++++++++++++
 tb/tb_mag_comparator_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comparator_seq.sv
// Sequential magnitude comparator: one 4-bit digit per CALC cycle, MSB digit first.
// Define MAG_COMPARATOR_SEQ_EARLY_EXIT_EN to leave CALC on the first differing digit.
module mag_comparator_seq #(
    parameter int p_nbits = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               sgn,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic               gt,
    output logic               lt,
    output logic               eq,
    output logic [1:0]         dbg_state_o
);
    // Handshakes: a transfer happens in a cycle where both val and rdy are 1;
    // the producer holds its payload stable until that cycle.
    localparam int N  = p_nbits / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [p_nbits-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               decided_q, decided_d;
    logic               gt_q, gt_d, lt_q, lt_d;
    logic [3:0]         dig_a, dig_b;
    logic               dig_diff, last_step;

    // Operands shift left each CALC cycle, so the digit under test is always the top nibble.
    assign dig_a    = a_q[p_nbits-1 -: 4];
    assign dig_b    = b_q[p_nbits-1 -: 4];
    assign dig_diff = (dig_a != dig_b);

`ifdef MAG_COMPARATOR_SEQ_EARLY_EXIT_EN
    assign last_step = (cnt_q == LAST_DIGIT) || dig_diff;
`else
    assign last_step = (cnt_q == LAST_DIGIT);
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    state_d   = CALC;
                    // Flipping both MSBs maps two's-complement order onto unsigned order.
                    a_d       = {in0[p_nbits-1] ^ sgn, in0[p_nbits-2:0]};
                    b_d       = {in1[p_nbits-1] ^ sgn, in1[p_nbits-2:0]};
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                end
            end
            CALC: begin
                a_d = {a_q[p_nbits-5:0], 4'h0};
                b_d = {b_q[p_nbits-5:0], 4'h0};
                if (!decided_q && dig_diff) begin
                    decided_d = 1'b1;
                    gt_d      = (dig_a > dig_b);
                    lt_d      = (dig_a < dig_b);
                end
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    assign istream_rdy = (state_q == IDLE);
    assign ostream_val = (state_q == DONE);
    assign gt          = ostream_val & gt_q;
    assign lt          = ostream_val & lt_q;
    assign eq          = ostream_val & ~gt_q & ~lt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Bench for mag_comparator_seq: scoreboard queue filled at request handshake, drained by a monitor.
// Follows MAG_COMPARATOR_SEQ_EARLY_EXIT_EN for the expected latency.
module tb_mag_comparator_seq;
    localparam int P = 16;
    localparam int N = P / 4;
    localparam int W = 43;  // {t[31:0], k[7:0], gt, lt, eq}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         istream_val = 1'b0;
    logic         istream_rdy;
    logic [P-1:0] in0 = '0;
    logic [P-1:0] in1 = '0;
    logic         sgn = 1'b0;
    logic         ostream_val;
    logic         ostream_rdy = 1'b1;
    logic         gt, lt, eq;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    bit rand_bp = 1'b0;
    int stall_left = 0;
    bit active = 1'b0;
    bit chk_idle_next = 1'b0;
    logic [W-1:0] cur;

    mag_comparator_seq #(.p_nbits(P)) dut (
        .clk(clk), .rst(rst),
        .istream_val(istream_val), .istream_rdy(istream_rdy),
        .in0(in0), .in1(in1), .sgn(sgn),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
        .gt(gt), .lt(lt), .eq(eq),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: ordering from integer arithmetic, latency from digit positions.
    function automatic logic [W-1:0] model(input logic [P-1:0] a, input logic [P-1:0] b,
                                           input logic s, input int t);
        int ia, ib, ua, ub, k, scale;
        bit found;
        logic g, l, e;
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        g = (ia > ib);
        l = (ia < ib);
        e = (ia == ib);
        k = N;
`ifdef MAG_COMPARATOR_SEQ_EARLY_EXIT_EN
        ua = int'(a);
        ub = int'(b);
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            scale = 16 ** (N - 1 - i);
            if (!found && ((ua / scale) % 16) != ((ub / scale) % 16)) begin
                k = i + 1;
                found = 1'b1;
            end
        end
`else
        ua = 0; ub = 0; scale = 0; found = 1'b0;
`endif
        return {t[31:0], k[7:0], g, l, e};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [P-1:0] a, input logic [P-1:0] b, input logic s,
                        input bit expect_result, input bit keep_val, output int hs);
        int waited;
        waited = 0;
        @(negedge clk);
        in0 = a;
        in1 = b;
        sgn = s;
        istream_val = 1'b1;
        while (!istream_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!istream_rdy) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: istream_rdy stayed 0 for %0d cycles", waited);
            istream_val = 1'b0;
            hs = -1;
            return;
        end
        hs = cyc;
        if (expect_result) exp_q.push_back(model(a, b, s, cyc));
        @(posedge clk);
        #1;
        in0 = P'($urandom);
        in1 = P'($urandom);
        sgn = 1'($urandom_range(0, 1));
        if (!keep_val) istream_val = 1'b0;
    endtask

    // Consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && ostream_val) begin
                ostream_rdy = 1'b0;
                stall_left--;
            end else if (rand_bp) begin
                ostream_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                ostream_rdy = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            chk_idle_next = 1'b0;
        end else begin
            if (chk_idle_next) begin
                check("rdy_after_accept", istream_rdy, 1);
                chk_idle_next = 1'b0;
            end
            if (ostream_val) begin
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: flags %b with empty queue", {gt, lt, eq});
                        cur = {32'd0, 8'd0, gt, lt, eq};
                    end else begin
                        cur = exp_q.pop_front();
                        check("latency", cyc, int'(cur[42:11]) + int'(cur[10:3]) + 1);
                        check("flags", {gt, lt, eq}, cur[2:0]);
                    end
                    active = 1'b1;
                end else begin
                    check("flags_held", {gt, lt, eq}, cur[2:0]);
                end
                check("in_rdy_in_done", istream_rdy, 0);
                if (ostream_rdy) begin
                    active = 1'b0;
                    chk_idle_next = 1'b1;
                end
            end else begin
                if (active) begin
                    checks++;
                    errors++;
                    $display("FAIL val_dropped: ostream_val fell before ostream_rdy");
                    active = 1'b0;
                end
                check("flags_outside_done", {gt, lt, eq}, 3'b000);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hs, hs_prev, k_prev, waited;
        logic [P-1:0] a, b;
        logic [W-1:0] m;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_in_rdy", istream_rdy, 1);
        check("reset_out_val", ostream_val, 0);
        check("reset_flags", {gt, lt, eq}, 3'b000);
        check("reset_state", dbg_state, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        send(16'h1234, 16'h1233, 1'b0, 1, 0, hs);
        send(16'h8000, 16'h0001, 1'b0, 1, 0, hs);
        send(16'h8000, 16'h0001, 1'b1, 1, 0, hs);
        send(16'hABCD, 16'hABCD, 1'b1, 1, 0, hs);

        // Held result under back-pressure while inputs wiggle
        stall_left = 3;
        send(16'h00F0, 16'h0F00, 1'b0, 1, 0, hs);
        repeat (10) begin
            @(posedge clk);
            #2;
            in0 = P'($urandom);
            in1 = P'($urandom);
        end

        // Reset in the second CALC cycle aborts the transaction
        send(16'h1111, 16'h1112, 1'b0, 0, 0, hs);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_rdy", istream_rdy, 1);
        check("abort_out_val", ostream_val, 0);
        check("abort_state", dbg_state, 0);
        send(16'h0002, 16'h0003, 1'b0, 1, 0, hs);

        // Back-to-back requests with istream_val held high
        hs_prev = -1;
        k_prev = 0;
        for (int i = 0; i < 3; i++) begin
            a = P'($urandom);
            b = (i == 1) ? a : P'($urandom);
            send(a, b, 1'(i % 2), 1, 1, hs);
            if (hs_prev >= 0) check("b2b_spacing", hs - hs_prev, k_prev + 2);
            m = model(a, b, 1'(i % 2), 0);
            k_prev = int'(m[10:3]);
            hs_prev = hs;
        end
        istream_val = 1'b0;

        // Random traffic with random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = P'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (P'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
                default: b = P'($urandom);
            endcase
            send(a, b, 1'($urandom_range(0, 1)), 1, 0, hs);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        // Drain
        waited = 0;
        while ((exp_q.size() != 0 || active) && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || active) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
